// File: rtl/ani_ifetch_pkg.sv
// Shared core package: word-address type, fetch buffer entry and opcode constants.
package ani_ifetch_pkg;

  typedef logic [31:0] word_addr_t;

  localparam logic [5:0] AR_TYPE = 6'b000000;
  localparam logic [5:0] M_TYPE  = 6'b100011;
  localparam logic [5:0] BR_TYPE = 6'b000100;
  localparam logic [5:0] SH_TYPE = 6'b000010;

  typedef struct packed {
    word_addr_t  npc;
    logic [31:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/ani_fetch_fifo.sv
// Circular prefetch FIFO of {npc, ir} entries with flush; DEPTH must be 2 or 4.
module ani_fetch_fifo
  import ani_ifetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so push at full is legal then.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ani_ifetch.sv
// Instruction fetch unit: issues word fetches to IMEM, buffers responses and handles redirects.
module ani_ifetch
  import ani_ifetch_pkg::*;
#(
  parameter word_addr_t  RESET_PC = 32'd0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        RN,
  output logic        imem_req,
  output word_addr_t  imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        br_en,
  input  word_addr_t  br_target,
  output logic        if_valid,
  output logic [31:0] if_ir,
  output word_addr_t  if_npc,
  input  logic        id_ready,
  output logic        fetch_err
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

  word_addr_t    pc;
  word_addr_t    resp_addr;
  logic          pending;
  logic          post_reset;
  logic          err;
  logic          accept;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  fetch_entry_t  entry;
  fetch_entry_t  head;

  assign pop  = !empty && id_ready && !br_en && !RN;
  assign push = imem_rvalid && pending && !post_reset && !br_en && !RN;

  assign entry.npc = resp_addr + 32'd1;
  assign entry.ir  = imem_rdata;

  // Occupancy is counted after this cycle's pop so back-to-back fetch
  // sustains one instruction per cycle; overflow is still impossible.
  always_comb begin
    occ      = {1'b0, count} + {{CW{1'b0}}, pending} - {{CW{1'b0}}, pop};
    imem_req = !RN && !br_en && (occ < CAP) && (!full || pop);
    accept   = imem_req && imem_ready;
  end

  assign imem_addr = RN ? RESET_PC : pc;
  assign if_valid  = !empty && !RN;
  assign if_ir     = head.ir;
  assign if_npc    = head.npc;
  assign fetch_err = err && !RN;

  always_ff @(posedge clk) begin
    if (RN) begin
      pc         <= RESET_PC;
      resp_addr  <= RESET_PC;
      pending    <= 1'b0;
      post_reset <= 1'b1;
      err        <= 1'b0;
    end else begin
      post_reset <= 1'b0;
      pending    <= accept;
      if (accept) resp_addr <= pc;
      if (br_en)       pc <= br_target;
      else if (accept) pc <= pc + 32'd1;
      // Responses right after reset belong to abandoned requests.
      if (imem_rvalid && !pending && !post_reset) err <= 1'b1;
    end
  end

  ani_fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (RN),
    .push (push),
    .pop  (pop),
    .flush(br_en),
    .din  (entry),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(count)
  );

endmodule
